dat_control: RTL

DAT_CONTROL -- requirements
Module: dat_control

---
 rtl/dat_control.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/dat_control.sv
`timescale 1ns/1ps
// dat_control: sequences the blocks of an SD data transfer. It hands each block
// to the DAT physical layer, waits for it to finish and for the card to release
// DAT0, counts the blocks that remain, and reports the end of the transfer or the
// first error.
module dat_control #(
   parameter int BLK_SZ_W  = 12,
   parameter int BLK_CNT_W = 16,
   parameter int TMO_W     = 16
) (
   input  logic                 sd_clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 dir,
   input  logic                 multi_blk,
   input  logic [BLK_CNT_W-1:0] blk_cnt_cfg,
   input  logic [BLK_SZ_W-1:0]  blk_sz_cfg,
   input  logic [TMO_W-1:0]     timeout_cfg,
   input  logic                 stop,
   input  logic                 data_phys_busy,
   input  logic                 phys_done,
   input  logic                 phys_crc_err,
   input  logic                 sdc_busy,
   input  logic                 tx_fifo_empty,
   input  logic                 rx_fifo_full,
   output logic                 write_flag,
   output logic                 read_flag,
   output logic [BLK_SZ_W-1:0]  block_sz,
   output logic [BLK_CNT_W-1:0] blk_rem,
   output logic                 xfer_active,
   output logic                 blk_done,
   output logic                 xfer_done,
   output logic                 xfer_err,
   output logic [1:0]           err_code
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_PHYS,
      WAIT_CARD,
      DONE,
      ERR
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE  = 2'b00,
      ERR_CRC   = 2'b01,
      ERR_TMO   = 2'b10,
      ERR_ABORT = 2'b11
   } err_t;

   state_t           state;
   logic             dir_q;      // 1 = write, held for the whole transfer
   logic [TMO_W-1:0] tmo_lim;    // timeout limit captured at start, 0 = disabled
   logic [TMO_W-1:0] tmo_cnt;
   logic [TMO_W-1:0] tmo_nxt;
   logic             tmo_hit;
   logic             fifo_ready;
   logic             unused_inputs;

   // The physical layer's busy flag is informational only; the FSM relies on
   // phys_done alone.
   assign unused_inputs = data_phys_busy;

   // Timeout fires on the cycle the count would reach the limit, so a limit of N
   // gives exactly N cycles in a waiting state.
   assign tmo_nxt = tmo_cnt + TMO_W'(1);
   assign tmo_hit = (tmo_lim != '0) && (tmo_nxt == tmo_lim);

   // A block may only start when its FIFO can source or sink the data.
   assign fifo_ready = dir_q ? !tx_fifo_empty : !rx_fifo_full;

   // Transfer FSM together with all of its registered outputs.
   // NOTE: every register here is written with <= so that all of them update
   // from the same pre-edge values; the async reset clears each one explicitly.
   always_ff @(posedge sd_clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         dir_q       <= 1'b0;
         tmo_lim     <= '0;
         tmo_cnt     <= '0;
         write_flag  <= 1'b0;
         read_flag   <= 1'b0;
         block_sz    <= '0;
         blk_rem     <= '0;
         xfer_active <= 1'b0;
         blk_done    <= 1'b0;
         xfer_done   <= 1'b0;
         xfer_err    <= 1'b0;
         err_code    <= ERR_NONE;
      end else begin
         // Pulse outputs default low and are raised for one cycle below.
         write_flag <= 1'b0;
         read_flag  <= 1'b0;
         blk_done   <= 1'b0;
         xfer_done  <= 1'b0;
         xfer_err   <= 1'b0;

         case (state)
            IDLE: begin
               if (start) begin
                  dir_q       <= dir;
                  block_sz    <= blk_sz_cfg;
                  tmo_lim     <= timeout_cfg;
                  tmo_cnt     <= '0;
                  err_code    <= ERR_NONE;
                  xfer_active <= 1'b1;
                  if (multi_blk) begin
                     blk_rem <= blk_cnt_cfg;
                     state   <= (blk_cnt_cfg == '0) ? DONE : ISSUE;
                  end else begin
                     blk_rem <= BLK_CNT_W'(1);
                     state   <= ISSUE;
                  end
               end
            end

            ISSUE: begin
               if (stop) begin
                  err_code <= ERR_ABORT;
                  state    <= ERR;
               end else if (fifo_ready) begin
                  write_flag <= dir_q;
                  read_flag  <= !dir_q;
                  tmo_cnt    <= '0;
                  state      <= WAIT_PHYS;
               end
            end

            WAIT_PHYS: begin
               if (stop) begin
                  err_code <= ERR_ABORT;
                  state    <= ERR;
               end else if (phys_done && phys_crc_err) begin
                  err_code <= ERR_CRC;
                  state    <= ERR;
               end else if (tmo_hit) begin
                  err_code <= ERR_TMO;
                  state    <= ERR;
               end else if (phys_done) begin
                  blk_done <= 1'b1;
                  blk_rem  <= (blk_rem != '0) ? blk_rem - BLK_CNT_W'(1) : '0;
                  if (dir_q) begin
                     tmo_cnt <= '0;
                     state   <= WAIT_CARD;
                  end else begin
                     state <= (blk_rem > BLK_CNT_W'(1)) ? ISSUE : DONE;
                  end
               end else begin
                  tmo_cnt <= tmo_nxt;
               end
            end

            WAIT_CARD: begin
               if (stop) begin
                  err_code <= ERR_ABORT;
                  state    <= ERR;
               end else if (tmo_hit) begin
                  err_code <= ERR_TMO;
                  state    <= ERR;
               end else if (!sdc_busy) begin
                  state <= (blk_rem != '0) ? ISSUE : DONE;
               end else begin
                  tmo_cnt <= tmo_nxt;
               end
            end

            DONE: begin
               if (stop) begin
                  err_code <= ERR_ABORT;
                  state    <= ERR;
               end else begin
                  xfer_done   <= 1'b1;
                  xfer_active <= 1'b0;
                  err_code    <= ERR_NONE;
                  state       <= IDLE;
               end
            end

            ERR: begin
               // err_code was set on entry and stays until the next start.
               xfer_err    <= 1'b1;
               xfer_active <= 1'b0;
               state       <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
